// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between instruction fetch and data memory.
// Data requests win arbitration, but after STARVE_LIMIT consecutive data
// grants with an instruction fetch waiting, the fetch is granted next.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload
);

    // RAM handshake encoding shared with the memory model
    localparam logic [1:0] RAM_FREE   = 2'd0;
    localparam logic [1:0] RAM_BUSY   = 2'd1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] scount_q, scount_d;
    logic       dreq;

    assign dreq  = dREN | dWEN;
    // Read data is passed straight through; it is only meaningful in the
    // cycle the owning side sees its wait drop.
    assign iload = ramload;
    assign dload = ramload;

    // Grant state and starvation counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            scount_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            scount_q <= scount_d;
        end
    end

    // Arbitration, RAM drive and wait generation
    always_comb begin
        state_d  = state_q;
        scount_d = scount_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = iREN;
        dwait    = dreq;
        case (state_q)
            IDLE: begin
                if (dreq && (!iREN || scount_q < LIMIT)) begin
                    state_d = DGRANT;
                    // count only data grants that overtake a waiting fetch
                    if (iREN && scount_q < LIMIT)
                        scount_d = scount_q + 4'd1;
                end else if (iREN) begin
                    state_d  = IGRANT;
                    scount_d = 4'd0;
                end else begin
                    scount_d = 4'd0;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    // fetch withdrawn: release the RAM without a wait pulse
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    // FREE/BUSY/ERROR all keep the request on the bus
                    if (ramstate == RAM_ACCESS) begin
                        iwait   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    // a write takes precedence if both enables are raised
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (ramstate == RAM_ACCESS) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a transaction-level owner/streak model.
module tb_ram_arbiter;

    localparam int LIMIT = 4;
    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_assert = 0;
    int n_fail   = 0;

    // model: who currently holds the RAM (0 none, 1 fetch, 2 data) and how
    // many data grants in a row have overtaken a waiting fetch
    int m_owner  = 0;
    int m_streak = 0;

    ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramstate(ramstate), .ramload(ramload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // expected outputs for the current cycle from the model's owner
    task automatic check_outputs();
        logic        dreq, e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store;
        dreq = dREN | dWEN;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'd0; e_store = 32'd0;
        e_iw = iREN; e_dw = dreq;
        if (m_owner == 1 && iREN) begin
            e_ren  = 1'b1;
            e_addr = iaddr;
            e_iw   = (ramstate != S_ACCESS);
        end else if (m_owner == 2 && dreq) begin
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_addr  = daddr;
            e_store = dstore;
            e_dw    = (ramstate != S_ACCESS);
        end
        chk("ramREN", 32'(ramREN), 32'(e_ren));
        chk("ramWEN", 32'(ramWEN), 32'(e_wen));
        chk("iwait",  32'(iwait),  32'(e_iw));
        chk("dwait",  32'(dwait),  32'(e_dw));
        chk("iload",  iload, ramload);
        chk("dload",  dload, ramload);
        if (e_ren || e_wen) chk("ramaddr", ramaddr, e_addr);
        if (e_wen)          chk("ramstore", ramstore, e_store);
    endtask

    // advance the model across the coming clock edge
    task automatic model_step();
        logic dreq;
        dreq = dREN | dWEN;
        if (!nRST) begin
            m_owner = 0; m_streak = 0;
        end else if (m_owner == 0) begin
            if (dreq && (!iREN || m_streak < LIMIT)) begin
                m_owner = 2;
                if (iREN) m_streak = m_streak + 1;
            end else if (iREN) begin
                m_owner = 1; m_streak = 0;
            end else begin
                m_streak = 0;
            end
        end else if (m_owner == 1) begin
            if (!iREN || ramstate == S_ACCESS) m_owner = 0;
        end else begin
            if (!dreq || ramstate == S_ACCESS) m_owner = 0;
        end
    endtask

    // called at posedge+1 with inputs set; returns at next posedge+1
    task automatic cycle();
        #2;
        check_outputs();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        string order;
        int    low_pulses;

        // ---- reset with a fetch pending ----
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0000_0040; daddr = 32'd0; dstore = 32'd0;
        ramstate = S_BUSY; ramload = 32'hDEAD_BEEF;
        #1;
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_iwait",  32'(iwait),  32'd1);
        chk("rst_ramaddr", ramaddr, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        cycle();             // idle, fetch seen
        cycle();             // granted, BUSY
        cycle();             // BUSY
        ramstate = S_ACCESS;
        #1;
        chk("rst_iwait_done", 32'(iwait), 32'd0);
        chk("rst_iload", iload, 32'hDEAD_BEEF);
        cycle();
        iREN = 1'b0;
        cycle();

        // ---- data write (both enables high, write wins) ----
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h100; dstore = 32'hCAFE_0001;
        ramstate = S_FREE;
        cycle();             // idle
        #1;
        chk("wr_ramWEN", 32'(ramWEN), 32'd1);
        chk("wr_ramREN", 32'(ramREN), 32'd0);
        chk("wr_ramaddr", ramaddr, 32'h100);
        chk("wr_ramstore", ramstore, 32'hCAFE_0001);
        chk("wr_dwait_hold", 32'(dwait), 32'd1);
        cycle();
        ramstate = S_ACCESS;
        #1;
        chk("wr_dwait_done", 32'(dwait), 32'd0);
        cycle();
        dWEN = 1'b0; dREN = 1'b0;
        cycle();

        // ---- priority / starvation with a 0-wait RAM ----
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h1000; daddr = 32'h2000;
        ramstate = S_ACCESS;
        order = "";
        for (int k = 0; k < 40 && order.len() < 10; k++) begin
            if (ramREN) order = {order, (ramaddr == 32'h1000) ? "I" : "D"};
            cycle();
        end
        n_assert++;
        assert (order == "DDDDIDDDDI") else begin
            n_fail++;
            $error("FAIL grant_order: observed %s expected DDDDIDDDDI", order);
        end
        iREN = 1'b0; dREN = 1'b0;
        cycle();
        cycle();

        // ---- ERROR retries then ACCESS ----
        dREN = 1'b1; daddr = 32'h300; ramstate = S_ERROR;
        low_pulses = 0;
        cycle();             // idle
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("err_ramREN", 32'(ramREN), 32'd1);
            chk("err_dwait", 32'(dwait), 32'd1);
            cycle();
        end
        ramstate = S_ACCESS;
        #1;
        if (!dwait) low_pulses++;
        cycle();
        dREN = 1'b0;
        #1;
        if (!dwait) low_pulses++;   // no request now, so not a completion
        cycle();
        chk("err_single_pulse", 32'(low_pulses), 32'd2);

        // ---- abort of a data read while BUSY ----
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h0440; daddr = 32'h0880;
        ramstate = S_BUSY;
        cycle();             // idle: data wins
        cycle();             // data granted, BUSY
        dREN = 1'b0;
        #1;
        chk("abort_ramREN", 32'(ramREN), 32'd0);
        chk("abort_dwait", 32'(dwait), 32'd0);
        cycle();             // abort cycle
        #1;
        chk("abort_idle_ramREN", 32'(ramREN), 32'd0);
        chk("abort_idle_iwait", 32'(iwait), 32'd1);
        cycle();             // idle
        #1;
        chk("abort_igrant_ramREN", 32'(ramREN), 32'd1);
        chk("abort_igrant_addr", ramaddr, 32'h0440);

        // ---- async reset in the middle of a fetch grant ----
        nRST = 1'b0;
        m_owner = 0; m_streak = 0;
        #1;
        chk("async_ramREN", 32'(ramREN), 32'd0);
        chk("async_scount", 32'(dut.scount_q), 32'd0);
        chk("async_iwait", 32'(iwait), 32'd1);
        @(posedge CLK); #1;
        nRST = 1'b1;
        #1;
        chk("async_idle_ramREN", 32'(ramREN), 32'd0);
        cycle();
        iREN = 1'b0;
        cycle();

        // ---- random traffic against the model ----
        for (int k = 0; k < 2000; k++) begin
            iREN   = ($urandom_range(3) != 0);
            dREN   = ($urandom_range(2) == 0);
            dWEN   = ($urandom_range(3) == 0);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            case ($urandom_range(19))
                0, 1, 2, 3:         ramstate = S_FREE;
                4, 5, 6, 7, 8, 9:   ramstate = S_BUSY;
                17, 18, 19:         ramstate = S_ERROR;
                default:            ramstate = S_ACCESS;
            endcase
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
